// File: rtl/tenkey_scan.sv
// tenkey_scan: 4x3 keypad row scanner with whole-frame debounce.
// Option TENKEY_SCAN_MULTI_HOLD_EN: multi-key frames never replace the accepted key.
module tenkey_scan #(
  parameter int SCAN_DIV = 250,
  parameter int DEB_CNT  = 4
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] tenkey,
  output logic       close
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0] K_NONE  = 4'd12;
  localparam logic [3:0] K_MULTI = 4'd13;

  logic [2:0]    col_s1;
  logic [2:0]    col_s2;
  logic [SW-1:0] slot;
  logic [1:0]    row;
  logic [11:0]   frame;
  logic [CW-1:0] cnt;
  logic [3:0]    prev;
  logic [3:0]    stable;

  logic          slot_end;
  logic          frame_end;
  logic [11:0]   full;
  logic [3:0]    cand;
  logic [CW-1:0] cnt_nx;
  logic          accept;
  logic [9:0]    tk_nx;
  logic          cl_nx;

  assign slot_end  = (slot == SLOT_LAST);
  assign frame_end = slot_end && (row == 2'd3);
  assign full      = {~col_s2, frame[8:0]};
  assign row_n     = ~(4'b0001 << row);

  // two-flop synchronizer for the asynchronous column pins
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      col_s1 <= 3'b111;
      col_s2 <= 3'b111;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // slot timer, row rotation and per-row column capture
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      slot  <= '0;
      row   <= 2'd0;
      frame <= '0;
    end else if (slot_end) begin
      slot <= '0;
      row  <= row + 2'd1;
      frame[int'(row)*3 +: 3] <= ~col_s2;
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // classify the completed frame, including the row-3 bits landing now
  always_comb begin
    int ones;
    logic [3:0] idx;
    ones = $countones(full);
    idx  = 4'd0;
    cand = K_NONE;
    for (int i = 0; i < 12; i++) begin
      if (full[i]) idx = 4'(i);
    end
    if (ones == 1) cand = idx;
    else if (ones > 1) cand = K_MULTI;
  end

  // run-length of identical frames, saturating at the accept threshold
  always_comb begin
    cnt_nx = CNT_ONE;
    if (cand == prev) begin
      cnt_nx = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    end
`ifdef TENKEY_SCAN_MULTI_HOLD_EN
    accept = (cnt_nx == CNT_MAX) && (cand != K_MULTI);
`else
    accept = (cnt_nx == CNT_MAX);
`endif
  end

  // debounce state updated once per frame
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      prev   <= K_NONE;
      stable <= K_NONE;
    end else if (frame_end) begin
      cnt  <= cnt_nx;
      prev <= cand;
      if (accept) stable <= cand;
    end
  end

  // key index to lock outputs: top rows read 1..9, bottom row is * 0 #
  always_comb begin
    tk_nx = '0;
    cl_nx = 1'b0;
    unique case (1'b1)
      (stable < 4'd9):   tk_nx[stable + 4'd1] = 1'b1;
      (stable == 4'd10): tk_nx[0] = 1'b1;
      (stable == 4'd11): cl_nx = 1'b1;
      default: ;
    endcase
  end

  // registered outputs
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      tenkey <= '0;
      close  <= 1'b0;
    end else begin
      tenkey <= tk_nx;
      close  <= cl_nx;
    end
  end

endmodule

// File: tb/tb_tenkey_scan.sv
// tb_tenkey_scan: frame-level keypad model and debounce reference.
// Runs SCAN_DIV=4, DEB_CNT=2 (16-cycle frames).
module tb_tenkey_scan;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int NONE  = 12;
  localparam int MULTI = 13;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] tenkey;
  logic       close;

  logic [11:0] pressed = '0;
  int checks = 0;
  int failures = 0;
  int hist[$];
  int stable_m = NONE;
  logic [9:0] obs_tk;
  logic       obs_cl;
  string keymap = "123456789*0#";

  tenkey_scan #(.SCAN_DIV(SD), .DEB_CNT(DB)) dut (
    .ck(ck), .reset(reset), .col_n(col_n),
    .row_n(row_n), .tenkey(tenkey), .close(close)
  );

  always #5 ck = ~ck;

  // physical keypad: a pressed key shorts its row line to its column line
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && pressed[r*3+c]) col_n[c] = 1'b0;
  end

  function automatic int classify(input logic [11:0] k);
    int n;
    int idx;
    n = $countones(k);
    idx = 0;
    for (int i = 0; i < 12; i++) if (k[i]) idx = i;
    if (n == 0) return NONE;
    if (n > 1) return MULTI;
    return idx;
  endfunction

  // {close, tenkey} expected for an accepted key
  function automatic logic [10:0] expect_out(input int key);
    logic [10:0] e;
    byte ch;
    e = '0;
    if (key < 12) begin
      ch = keymap[key];
      if (ch >= "0" && ch <= "9") e[ch - "0"] = 1'b1;
      else if (ch == "#") e[10] = 1'b1;
    end
    return e;
  endfunction

  // accept a candidate once the last DB frames all agree on it
  task automatic model_frame(input logic [11:0] keys);
    int cand;
    bit same;
    cand = classify(keys);
    hist.push_back(cand);
    if (hist.size() > 8) void'(hist.pop_front());
    same = hist.size() >= DB;
    for (int i = 0; i < DB && same; i++)
      if (hist[hist.size()-1-i] != cand) same = 0;
`ifdef TENKEY_SCAN_MULTI_HOLD_EN
    if (cand == MULTI) same = 0;
`endif
    if (same) stable_m = cand;
  endtask

  task automatic model_reset();
    hist.delete();
    stable_m = NONE;
  endtask

  // one aligned frame: entered and left at the negedge of slot cycle 0
  task automatic frame(input logic [11:0] keys);
    logic [10:0] e;
    pressed = keys;
    repeat (8) @(posedge ck);
    @(negedge ck);
    e = expect_out(stable_m);
    obs_tk = tenkey;
    obs_cl = close;
    checks++;
    if ({close, tenkey} !== e) begin
      failures++;
      $display("FAIL frame_out actual close=%b tenkey=%b required close=%b tenkey=%b",
               close, tenkey, e[10], e[9:0]);
    end
    checks++;
    if (row_n !== 4'b1011) begin
      failures++;
      $display("FAIL frame_row actual %b required 1011", row_n);
    end
    checks++;
    if (!$onehot0(tenkey) || (close && tenkey != 0)) begin
      failures++;
      $display("FAIL exclusive actual close=%b tenkey=%b required onehot0 exclusive",
               close, tenkey);
    end
    repeat (8) @(posedge ck);
    @(negedge ck);
    model_frame(keys);
  endtask

  task automatic chk_obs(input string nm, input logic [9:0] tk, input logic cl);
    checks++;
    if (obs_tk !== tk || obs_cl !== cl) begin
      failures++;
      $display("FAIL %s actual tenkey=%b close=%b required tenkey=%b close=%b",
               nm, obs_tk, obs_cl, tk, cl);
    end
  endtask

  task automatic test_reset();
    @(negedge ck);
    reset = 1'b1;
    pressed = '0;
    #1;
    checks++;
    if (row_n !== 4'b1110 || tenkey !== 10'd0 || close !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals actual row_n=%b tenkey=%b close=%b required 1110/0/0",
               row_n, tenkey, close);
    end
    @(negedge ck);
    reset = 1'b0;
    model_reset();
    repeat (4) @(posedge ck);
    @(negedge ck);
    checks++;
    if (row_n !== 4'b1101) begin
      failures++;
      $display("FAIL reset_row1 actual %b required 1101", row_n);
    end
    repeat (12) @(posedge ck);
    @(negedge ck);
    model_frame('0);
  endtask

  task automatic test_digit();
    for (int i = 0; i < 5; i++) begin
      frame(12'b0000_0001_0000);
      if (i == 2) chk_obs("digit5_press", 10'b00000_100000, 1'b0);
    end
    for (int i = 0; i < 3; i++) frame('0);
    chk_obs("digit5_release", 10'd0, 1'b0);
  endtask

  task automatic test_close();
    for (int i = 0; i < 3; i++) frame(12'b1000_0000_0000);
    chk_obs("hash_press", 10'd0, 1'b1);
    for (int i = 0; i < 3; i++) frame('0);
    chk_obs("hash_release", 10'd0, 1'b0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      frame((i % 2 == 0) ? 12'b0000_1000_0000 : 12'd0);
      chk_obs("bounce8", 10'd0, 1'b0);
    end
  endtask

  task automatic test_multi();
    for (int i = 0; i < 3; i++) frame(12'b0000_0000_0100);
    chk_obs("multi_first3", 10'b00000_01000, 1'b0);
    for (int i = 0; i < 3; i++) frame(12'b0000_0100_0100);
`ifdef TENKEY_SCAN_MULTI_HOLD_EN
    chk_obs("multi_hold", 10'b00000_01000, 1'b0);
`else
    chk_obs("multi_clear", 10'd0, 1'b0);
`endif
    for (int i = 0; i < 3; i++) frame(12'b0000_0000_0100);
    chk_obs("multi_release7", 10'b00000_01000, 1'b0);
    for (int i = 0; i < 3; i++) frame('0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) frame(12'b0100_0000_0000);
    chk_obs("zero_press", 10'b00000_00001, 1'b0);
    repeat (5) @(posedge ck);
    @(negedge ck);
    reset = 1'b1;
    #1;
    checks++;
    if (tenkey !== 10'd0 || close !== 1'b0 || row_n !== 4'b1110) begin
      failures++;
      $display("FAIL reset_mid actual tenkey=%b close=%b row_n=%b required 0/0/1110",
               tenkey, close, row_n);
    end
    @(negedge ck);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) frame(12'b0100_0000_0000);
    chk_obs("zero_again", 10'b00000_00001, 1'b0);
    for (int i = 0; i < 3; i++) frame('0);
  endtask

  task automatic test_random();
    logic [11:0] k;
    int kind;
    int a;
    int b;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 11);
      b = (a + $urandom_range(1, 11)) % 12;
      k = '0;
      if (kind == 1 || kind == 2) k[a] = 1'b1;
      if (kind == 3) begin
        k[a] = 1'b1;
        k[b] = 1'b1;
      end
      repeat ($urandom_range(1, 3)) frame(k);
    end
    for (int i = 0; i < 3; i++) frame('0);
  endtask

  initial begin
    test_reset();
    test_digit();
    test_close();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tenkey_scan.md
# tenkey_scan

Matrix keypad scanner and debouncer that produces the `tenkey` and `close` signals consumed by the electronic-lock controller. It drives a 4-row x 3-column keypad, samples the columns, debounces whole scan frames, and presents a stable one-hot digit (0-9) or a `close` level from the '#' key. It sits between the keypad pins and the lock, in the same clock domain as the lock.

## Interface
- SCAN_DIV, 250: clock cycles per row slot; must be at least 4.
- DEB_CNT, 4: consecutive identical frames required to accept a change; must be at least 1.

- ck  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- col_n  in  3  column sense, active-low, pulled up externally; asynchronous to `ck`.
- row_n  out  4  row drive, active-low; exactly one bit low at any time.
- tenkey  out  10  one-hot digit; bit n = digit n; all zero when no digit is accepted.
- close  out  1  high while '#' is the accepted key.

## Operation
- Keypad map, columns 0..2 left to right:
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = * 0 #
- col_n passes through a 2-flop synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1.
  - At wrap, the row index advances 0→1→2→3→0.
  - row_n = ~(1 << row index).
- On the last cycle of each slot, the synchronized ~col_n is written into 3 bits of a 12-bit frame register for the current row.
- Frame end = last cycle of row-3 slot. At frame end, classify the frame:
  - Exactly one bit set: candidate = that key.
  - No bits set: candidate = NONE.
  - Two or more bits set: candidate = MULTI.
- Debounce, evaluated at frame end:
  - If candidate == prev, cnt <= min(cnt+1, DEB_CNT); otherwise cnt <= 1.
  - prev <= candidate.
  - When the new cnt equals DEB_CNT, stable <= candidate (MULTI handled per Configuration).
- Outputs are registered from `stable`:
  - Digit d: tenkey = 1<<d, close = 0.
  - '#': tenkey = 0, close = 1.
  - '*', NONE or MULTI: tenkey = 0, close = 0.
- tenkey is never more than one-hot. tenkey and close are never high together.
- Holding a key produces one continuous level, with no auto-repeat. The lock derives its edge from this level.

## Timing
- Reset values:
  - row_n = 4'b1110; tenkey = 0; close = 0.
  - Slot counter, row index, frame register and cnt = 0.
  - prev = NONE; stable = NONE.
- Reset asserted mid-operation clears everything immediately, including held outputs. Detection restarts from row 0.
- Frame period = 4*SCAN_DIV cycles.
- Press latency, from the first complete clean frame to the outputs:
  - Stable is updated at the end of the DEB_CNT-th identical frame.
  - tenkey/close change 1 cycle later.
  - Worst case from press: (DEB_CNT+1) frames + 3 cycles, including the synchronizer.
- Release is debounced identically: NONE must persist DEB_CNT frames.
- A change of key, whether direct or through MULTI, restarts the count at 1.
- A key pressed or released mid-frame yields a partial frame. That frame simply fails to match and costs one extra frame.

## Configuration
- TENKEY_SCAN_MULTI_HOLD_EN
  - Defined: a MULTI candidate never updates stable; the previously accepted output holds until a clean single key or NONE is accepted.
  - Undefined: MULTI is accepted like any candidate and forces tenkey = 0, close = 0.

## Test plan
Run with SCAN_DIV=4, DEB_CNT=2, giving a frame of 16 cycles.
- Reset: pulse reset → row_n=4'b1110, tenkey=0, close=0; after 4 cycles row_n=4'b1101.
- Digit press: pull col_n[1] low whenever row_n[1] is low, held for 5 frames → tenkey=10'b00000_100000 ('5') within 3 frames + 3 cycles. Release → tenkey=0 within the same bound.
- Close key: '#' held (row3, col2) → close=1, tenkey=0. Release → close=0.
- Bounce: '8' present in alternate frames only, for 10 frames → tenkey stays 0 and cnt never reaches 2.
- Multi-key: accept '3', then add '7' while '3' is held:
  - Macro undefined → tenkey goes 0 after 2 frames.
  - Macro defined → tenkey stays 10'b00000_01000.
  - Release '7' → '3' remains or is re-accepted in both builds.
- Reset mid-press: assert reset while '0' is accepted → tenkey=0 immediately. Keep holding '0' → tenkey=10'b00000_00001 again within 3 frames + 3 cycles.
